bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 114 +++++++++++
 1 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per clock, MSB first).
// Results are registered on entry to the one-cycle DONE state and held until the next one.
module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [4*DIGITS-1:0]   o_bcd,
  output logic                  o_overflow
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned BW = 4 * DIGITS;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  bin_q, bin_d;
  logic [BW-1:0]     scr_q, scr_d;
  logic              ovf_q, ovf_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              ovfo_q, ovfo_d;

  logic [BW-1:0]     adj;
  logic [3:0]        dig;
  logic [BW-1:0]     shifted;
  logic              shifted_ovf;

  // Add 3 to every scratch digit >= 5, then form the shifted scratch and sticky overflow.
  always_comb begin
    adj = '0;
    dig = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      dig = scr_q[4*k +: 4];
      adj[4*k +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end
    shifted     = {adj[BW-2:0], bin_q[WIDTH-1]};
    // The bit leaving the top digit means the value no longer fits in DIGITS digits.
    shifted_ovf = ovf_q | adj[BW-1];
  end

  // Next-state and datapath updates for the IDLE/SHIFT/DONE controller.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    scr_d   = scr_q;
    ovf_d   = ovf_q;
    bcd_d   = bcd_q;
    ovfo_d  = ovfo_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          state_d = StShift;
          bin_d   = i_bin;
          scr_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = CW'(WIDTH);
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        scr_d = shifted;
        ovf_d = shifted_ovf;
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
          // Saturate to all nines on overflow so every nibble stays a legal digit.
          bcd_d   = shifted_ovf ? {DIGITS{4'h9}} : shifted;
          ovfo_d  = shifted_ovf;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bin_q   <= '0;
      scr_q   <= '0;
      ovf_q   <= 1'b0;
      bcd_q   <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      scr_q   <= scr_d;
      ovf_q   <= ovf_d;
      bcd_q   <= bcd_d;
      ovfo_q  <= ovfo_d;
    end
  end

  // Status flags decode directly from the state register.
  always_comb begin
    o_busy     = (state_q == StShift);
    o_done     = (state_q == StDone);
    o_bcd      = bcd_q;
    o_overflow = ovfo_q;
  end

endmodule
